// File: rtl/pc_branch_sequencer_if.sv
// Fetch/core handshake bundle for the PC sequencer.
// master is the sequencer side, slave is the memory + core side.
interface pc_branch_sequencer_if #(parameter int CNT_W = 32);
    logic              imem_req_valid;
    logic [31:0]       imem_req_addr;
    logic              imem_req_ready;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              instr_valid;
    logic [31:0]       instr;
    logic [31:0]       instr_pc;
    logic              instr_ready;
    logic              branch_en;
    logic              branch_taken;
    logic [31:0]       branch_target;
    logic              jump_en;
    logic [31:0]       jump_target;
    logic              misalign_err;
    logic [CNT_W-1:0]  retired_cnt;
    logic [CNT_W-1:0]  taken_cnt;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_valid, instr, instr_pc,
        input  instr_ready, branch_en, branch_taken, branch_target, jump_en, jump_target,
        output misalign_err, retired_cnt, taken_cnt
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instr, instr_pc,
        output instr_ready, branch_en, branch_taken, branch_target, jump_en, jump_target,
        input  misalign_err, retired_cnt, taken_cnt
    );
endinterface

// File: rtl/pc_branch_sequencer.sv
// Program counter owner: fetches one instruction at a time, hands it to the core,
// and picks the next PC from jump/branch results; stops on a misaligned redirect.
module pc_branch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    pc_branch_sequencer_if.master  bus
);
    typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, ERR} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t           state;
    logic [31:0]      pc;
    logic [31:0]      instr_q;
    logic [31:0]      instr_pc_q;
    logic             req_valid_q;
    logic             instr_valid_q;
    logic             err_q;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] taken_q;

    logic             taken;
    logic [31:0]      tgt;

    // Jump wins over branch; JAL/JALR targets have bit0 cleared.
    always_comb begin
        taken = 1'b0;
        tgt   = pc + 32'd4;
        if (bus.jump_en) begin
            taken = 1'b1;
            tgt   = bus.jump_target & 32'hFFFF_FFFE;
        end else if (bus.branch_en && bus.branch_taken) begin
            taken = 1'b1;
            tgt   = bus.branch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BOOT;
            pc            <= RESET_PC;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            err_q         <= 1'b0;
            retired_q     <= '0;
            taken_q       <= '0;
        end else begin
            unique case (state)
                BOOT: begin
                    req_valid_q <= 1'b1;
                    state       <= REQ;
                end
                REQ: begin
                    if (bus.imem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        instr_q       <= bus.imem_rsp_data;
                        instr_pc_q    <= pc;
                        instr_valid_q <= 1'b1;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        instr_valid_q <= 1'b0;
                        retired_q     <= retired_q + CNT_ONE;
                        if (taken)
                            taken_q <= taken_q + CNT_ONE;
                        // A misaligned redirect still retires, but the PC stays put.
                        if (taken && tgt[1]) begin
                            err_q <= 1'b1;
                            state <= ERR;
                        end else begin
                            pc          <= tgt;
                            req_valid_q <= 1'b1;
                            state       <= REQ;
                        end
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: state <= BOOT;
            endcase
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc;
    assign bus.instr_valid    = instr_valid_q;
    assign bus.instr          = instr_q;
    assign bus.instr_pc       = instr_pc_q;
    assign bus.misalign_err   = err_q;
    assign bus.retired_cnt    = retired_q;
    assign bus.taken_cnt      = taken_q;
endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Directed + randomized bench for pc_branch_sequencer against a transaction-level
// model (PC, retired/taken counts, error flag) updated once per retired instruction.
module tb_pc_branch_sequencer;
    localparam int          CNT_W    = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_branch_sequencer_if #(.CNT_W(CNT_W)) bus ();

    pc_branch_sequencer #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic [31:0] m_tkn;
    bit          m_err;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.instr_ready    = 1'b0;
        bus.branch_en      = 1'b0;
        bus.branch_taken   = 1'b0;
        bus.branch_target  = 32'h0;
        bus.jump_en        = 1'b0;
        bus.jump_target    = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        rst   = 1'b0;
        m_pc  = RESET_PC;
        m_ret = 0;
        m_tkn = 0;
        m_err = 1'b0;
        chk("rst_req_valid",   bus.imem_req_valid, 0);
        chk("rst_instr_valid", bus.instr_valid, 0);
        chk("rst_instr",       bus.instr, 0);
        chk("rst_instr_pc",    bus.instr_pc, 0);
        chk("rst_misalign",    bus.misalign_err, 0);
        chk("rst_retired",     bus.retired_cnt, 0);
        chk("rst_taken",       bus.taken_cnt, 0);
        step();
        chk("boot_req_valid",  bus.imem_req_valid, 1);
        chk("boot_req_addr",   bus.imem_req_addr, RESET_PC);
    endtask

    // One full fetch/execute transaction. kind: 0 sequential, 1 branch, 2 jump (+random branch).
    task automatic do_instr(input int rq_st, input int rs_st, input int co_st, input int kind,
                            input logic [31:0] bt, input logic [31:0] jt, input bit bk);
        logic [31:0] data;
        logic [31:0] tgt;
        bit          tk;
        for (int i = 0; i < rq_st; i++) begin
            bus.imem_rsp_valid = 1'($urandom_range(0, 1));
            bus.imem_rsp_data  = $urandom;
            chk("req_valid_stall", bus.imem_req_valid, 1);
            chk("req_addr_stall",  bus.imem_req_addr, m_pc);
            step();
        end
        chk("req_valid", bus.imem_req_valid, 1);
        chk("req_addr",  bus.imem_req_addr, m_pc);
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        chk("wait_req_valid",   bus.imem_req_valid, 0);
        chk("wait_instr_valid", bus.instr_valid, 0);
        for (int i = 0; i < rs_st; i++) begin
            step();
            chk("wait_instr_valid_stall", bus.instr_valid, 0);
            chk("wait_addr_stall",        bus.imem_req_addr, m_pc);
        end
        data = $urandom;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        step();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = $urandom;
        chk("hold_instr_valid", bus.instr_valid, 1);
        chk("hold_instr",       bus.instr, data);
        chk("hold_instr_pc",    bus.instr_pc, m_pc);
        for (int i = 0; i < co_st; i++) begin
            bus.branch_en     = 1'($urandom_range(0, 1));
            bus.branch_taken  = 1'($urandom_range(0, 1));
            bus.branch_target = $urandom;
            bus.jump_en       = 1'($urandom_range(0, 1));
            bus.jump_target   = $urandom;
            step();
            chk("stall_instr_valid", bus.instr_valid, 1);
            chk("stall_instr",       bus.instr, data);
            chk("stall_instr_pc",    bus.instr_pc, m_pc);
            chk("stall_retired",     bus.retired_cnt, m_ret);
            chk("stall_taken",       bus.taken_cnt, m_tkn);
            chk("stall_req_valid",   bus.imem_req_valid, 0);
        end
        bus.branch_en     = (kind == 1) ? 1'b1 : (kind == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.branch_taken  = (kind == 1) ? bk : 1'($urandom_range(0, 1));
        bus.branch_target = bt;
        bus.jump_en       = (kind == 2);
        bus.jump_target   = jt;
        bus.instr_ready   = 1'b1;
        step();
        idle_inputs();
        tk  = 1'b0;
        tgt = m_pc + 32'd4;
        if (kind == 2) begin
            tk  = 1'b1;
            tgt = {jt[31:1], 1'b0};
        end else if (kind == 1 && bk) begin
            tk  = 1'b1;
            tgt = bt;
        end
        m_ret = m_ret + 1;
        if (tk) m_tkn = m_tkn + 1;
        if (tk && tgt[1]) m_err = 1'b1;
        else m_pc = tgt;
        chk("post_instr_valid", bus.instr_valid, 0);
        chk("post_retired",     bus.retired_cnt, m_ret);
        chk("post_taken",       bus.taken_cnt, m_tkn);
        chk("post_misalign",    bus.misalign_err, m_err);
        chk("post_req_valid",   bus.imem_req_valid, !m_err);
        chk("post_req_addr",    bus.imem_req_addr, m_pc);
    endtask

    initial begin
        logic [31:0] bt;
        logic [31:0] jt;
        idle_inputs();
        do_reset();

        // 1: plain sequential fetch, minimum latency
        for (int i = 0; i < 4; i++) begin
            do_instr(0, 0, 0, 0, 32'h0, 32'h0, 1'b0);
            chk("t1_addr", bus.imem_req_addr, 32'(4 * (i + 1)));
        end
        chk("t1_retired", bus.retired_cnt, 4);
        chk("t1_taken",   bus.taken_cnt, 0);

        // 2: taken then not-taken branch
        do_instr(0, 0, 0, 1, 32'h40, 32'h0, 1'b1);
        chk("t2_taken_addr", bus.imem_req_addr, 32'h40);
        chk("t2_taken_cnt",  bus.taken_cnt, 1);
        do_instr(0, 0, 0, 1, 32'h80, 32'h0, 1'b0);
        chk("t2_nt_addr", bus.imem_req_addr, 32'h44);
        chk("t2_nt_cnt",  bus.taken_cnt, 1);

        // 3: jump beats branch, bit0 cleared
        do_instr(0, 0, 0, 2, 32'h20, 32'h81, 1'b1);
        chk("t3_addr", bus.imem_req_addr, 32'h80);

        // 4: stalls everywhere with junk branch inputs
        do_instr(5, 4, 3, 0, 32'h0, 32'h0, 1'b0);
        chk("t4_addr", bus.imem_req_addr, 32'h84);
        do_instr(5, 4, 3, 1, 32'h100, 32'h0, 1'b1);

        // 5: misaligned taken branch -> sticky error, fetch stops
        do_instr(0, 0, 0, 1, 32'h42, 32'h0, 1'b1);
        chk("t5_misalign", bus.misalign_err, 1);
        for (int i = 0; i < 6; i++) begin
            bus.imem_req_ready = 1'b1;
            bus.imem_rsp_valid = 1'($urandom_range(0, 1));
            bus.instr_ready    = 1'b1;
            bus.jump_en        = 1'b1;
            bus.jump_target    = 32'h200;
            step();
            chk("t5_req_valid",   bus.imem_req_valid, 0);
            chk("t5_instr_valid", bus.instr_valid, 0);
            chk("t5_misalign",    bus.misalign_err, 1);
            chk("t5_pc_frozen",   bus.imem_req_addr, m_pc);
            chk("t5_retired",     bus.retired_cnt, m_ret);
        end
        do_reset();

        // 6: reset during WAIT, stale response ignored
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        chk("t6_in_wait", bus.imem_req_valid, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        m_pc = RESET_PC; m_ret = 0; m_tkn = 0; m_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t6_no_instr_valid", bus.instr_valid, 0);
            step();
        end
        bus.imem_rsp_valid = 1'b0;
        chk("t6_req_valid", bus.imem_req_valid, 1);
        chk("t6_req_addr",  bus.imem_req_addr, RESET_PC);
        chk("t6_instr",     bus.instr, 0);
        do_instr(0, 0, 0, 2, 32'h0, 32'hFFFF_FFFC, 1'b0);
        chk("t6_top_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        do_instr(0, 0, 0, 0, 32'h0, 32'h0, 1'b0);
        chk("t6_wrap_addr", bus.imem_req_addr, 32'h0000_0000);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            if (m_err) do_reset();
            bt = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
            jt = ($urandom & 32'hFFFF_FFFD) | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
            do_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 2), bt, jt, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
